frequency_divider: RTL and testbench
====================================

// Module: frequency_divider
// PURPOSE
//   Parameterised clock-enable / divided-clock generator for SoC peripherals
//   (e.g. the SD SPI clock). Counts cycles of inputCLK and toggles a divided
//   output every `divider` enabled cycles. Also emits single-cycle strobes so
//   downstream logic can stay in the inputCLK domain instead of using
//   outputCLK as a clock.
// PARAMETERS
//   divider     2  enabled input cycles per outputCLK half-period; legal range >= 1
//   bitsNumber  2  counter width; must satisfy 2**bitsNumber >= divider
// PORTS
//   inputCLK   in   1           sole clock; all logic on its rising edge
//   reset      in   1           synchronous, active-low reset
//   enable     in   1           1 = count; 0 = freeze count and outputCLK
//   outputCLK  out  1           divided clock; period 2*divider enabled cycles, 50% duty
//   tick       out  1           one-cycle strobe, high on every outputCLK toggle
//   rise       out  1           one-cycle strobe, high when outputCLK goes 0->1
//   fall       out  1           one-cycle strobe, high when outputCLK goes 1->0
//   count      out  bitsNumber  current phase counter value, 0..divider-1
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-low.
//   - Reset: reset==0 at a rising edge forces count=0, outputCLK=0, and
//     tick=rise=fall=0. Reset has priority over enable.
//   - Reset mid-operation is honoured on the next edge regardless of phase.
//   - All outputs are registered. No combinational path from inputs to outputs.
//   - enable==1 and count!=divider-1: count<=count+1.
//     In the same case, outputCLK holds and all strobes are 0.
//   - enable==1 and count==divider-1 (wrap): count<=0 and outputCLK<=~outputCLK.
//     tick<=1; rise<=~outputCLK(old); fall<=outputCLK(old).
//   - enable==0: count and outputCLK hold; tick/rise/fall<=0.
//     Phase resumes exactly where it stopped.
//   - Strobes are high for exactly one inputCLK cycle, only on the wrap edge.
//   - Latency: the first toggle (0->1) lands on the divider-th enabled edge
//     after reset release.
//   - divider==1: count stays 0; outputCLK toggles on every enabled edge
//     (inputCLK/2); tick is high continuously while enabled.
//   - count never exceeds divider-1. No unsigned overflow when divider==2**bitsNumber.
//   - Elaboration check: divider<1 or 2**bitsNumber<divider triggers $error.
//     Synthesis must not proceed.
// TESTING  (divider=2, bitsNumber=2, enable=1 unless stated;
//           edge N = Nth rising edge with reset=1)
//   1. Reset: hold reset=0 for 3 edges
//      -> count=0, outputCLK=0, tick=rise=fall=0.
//   2. Release reset
//      -> count 1,0,1,0 on edges 1-4; outputCLK=1 after edge 2, 0 after edge 4.
//      Strobes: tick=1 after edges 2 and 4; rise=1 only after edge 2;
//      fall=1 only after edge 4.
//   3. Free run 80000 edges -> outputCLK period exactly 4 cycles, 50% duty.
//      Exactly one tick per 2 cycles; rise and fall alternate.
//   4. enable=0 for 5 edges with count=1
//      -> count and outputCLK frozen, strobes 0.
//      After re-enable, the next edge wraps and toggles.
//   5. Drive reset=0 for one edge while outputCLK=1, count=1
//      -> next edge count=0, outputCLK=0, no fall strobe.
//   6. Re-elaborate with divider=1, then with divider=3/bitsNumber=2
//      -> divider=1: toggle every edge.
//      -> divider=3: period 6, count sequence 0,1,2,0.
//      -> divider=5/bitsNumber=2 raises an elaboration error.

Source files
------------

// File: rtl/frequency_divider.sv
`default_nettype none
// ============================================================================
// Module   : frequency_divider
// Brief    : Divided clock plus single-cycle tick/rise/fall strobes in the
//            inputCLK domain. Counts enabled cycles and toggles every divider.
// Revision : 1.0 - initial release
// ============================================================================
module frequency_divider #(
  parameter int divider    = 2,
  parameter int bitsNumber = 2
) (
  input  logic                  inputCLK,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  outputCLK,
  output logic                  tick,
  output logic                  rise,
  output logic                  fall,
  output logic [bitsNumber-1:0] count
);

  // Illegal parameter sets stop elaboration.
  if (divider < 1 || (2 ** bitsNumber) < divider) begin : g_bad_params
    $error("frequency_divider: illegal divider=%0d / bitsNumber=%0d", divider, bitsNumber);
  end

  localparam logic [bitsNumber-1:0] LAST_COUNT = bitsNumber'(divider - 1);

  logic [bitsNumber-1:0] count_q, count_d;
  logic                  out_q, out_d;
  logic                  tick_q, tick_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  // Wrap compares against divider-1, so count+1 is never taken at the top
  // value and the counter cannot overflow even when divider == 2**bitsNumber.
  always_comb begin
    count_d = count_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (enable) begin
      if (count_q == LAST_COUNT) begin
        count_d = '0;
        out_d   = ~out_q;
        tick_d  = 1'b1;
        rise_d  = ~out_q;
        fall_d  = out_q;
      end else begin
        count_d = count_q + bitsNumber'(1);
      end
    end
  end

  always_ff @(posedge inputCLK) begin
    if (!reset) begin
      count_q <= '0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign count     = count_q;
  assign outputCLK = out_q;
  assign tick      = tick_q;
  assign rise      = rise_q;
  assign fall      = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_frequency_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_frequency_divider
// Brief    : Self-checking bench: directed vector table plus randomized run
//            against an arithmetic model, for divider = 1, 2, 3 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frequency_divider;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  logic       oc1, tk1, ri1, fa1;
  logic [0:0] cnt1;
  logic       oc2, tk2, ri2, fa2;
  logic [1:0] cnt2;
  logic       oc3, tk3, ri3, fa3;
  logic [1:0] cnt3;
  logic       oc4, tk4, ri4, fa4;
  logic [1:0] cnt4;

  frequency_divider #(.divider(2), .bitsNumber(2)) dut (
    .inputCLK(clk), .reset(rst_n), .enable(en),
    .outputCLK(oc2), .tick(tk2), .rise(ri2), .fall(fa2), .count(cnt2)
  );

  frequency_divider #(.divider(1), .bitsNumber(1)) dut_d1 (
    .inputCLK(clk), .reset(rst_n), .enable(en),
    .outputCLK(oc1), .tick(tk1), .rise(ri1), .fall(fa1), .count(cnt1)
  );

  frequency_divider #(.divider(3), .bitsNumber(2)) dut_d3 (
    .inputCLK(clk), .reset(rst_n), .enable(en),
    .outputCLK(oc3), .tick(tk3), .rise(ri3), .fall(fa3), .count(cnt3)
  );

  frequency_divider #(.divider(4), .bitsNumber(2)) dut_d4 (
    .inputCLK(clk), .reset(rst_n), .enable(en),
    .outputCLK(oc4), .tick(tk4), .rise(ri4), .fall(fa4), .count(cnt4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: enabled edges since reset, and whether the last edge was enabled.
  int n_en    = 0;
  bit last_en = 1'b0;

  function automatic void cmp(string name, int act, int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp_v, $time);
    end
  endfunction

  function automatic void check_one(string tag, int d, int ac, int ao, int at, int ar, int af);
    int ec, eo, et;
    ec = n_en % d;
    eo = (n_en / d) % 2;
    et = (last_en && (n_en % d == 0)) ? 1 : 0;
    cmp({tag, ".count"},     ac, ec);
    cmp({tag, ".outputCLK"}, ao, eo);
    cmp({tag, ".tick"},      at, et);
    cmp({tag, ".rise"},      ar, (et == 1 && eo == 1) ? 1 : 0);
    cmp({tag, ".fall"},      af, (et == 1 && eo == 0) ? 1 : 0);
  endfunction

  function automatic void check_all();
    check_one("d1", 1, int'(cnt1), int'(oc1), int'(tk1), int'(ri1), int'(fa1));
    check_one("d2", 2, int'(cnt2), int'(oc2), int'(tk2), int'(ri2), int'(fa2));
    check_one("d3", 3, int'(cnt3), int'(oc3), int'(tk3), int'(ri3), int'(fa3));
    check_one("d4", 4, int'(cnt4), int'(oc4), int'(tk4), int'(ri4), int'(fa4));
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      n_en    = 0;
      last_en = 1'b0;
    end else if (en) begin
      n_en++;
      last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    #1;
    check_all();
  endtask

  typedef struct {
    bit rst_n;
    bit en;
    int cnt;
    bit oc;
    bit tk;
    bit ri;
    bit fa;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int last_rise;
    int last_strobe;   // 1 = rise, 0 = fall, -1 = none yet

    // Directed table for divider=2: inputs before the edge, outputs after it.
    vecs[0]  = '{0, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 0, 1, 1, 1, 0};
    vecs[5]  = '{1, 1, 1, 1, 0, 0, 0};
    vecs[6]  = '{1, 1, 0, 0, 1, 0, 1};
    vecs[7]  = '{1, 1, 1, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{1, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 1, 0, 0, 0, 0};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 0};
    vecs[13] = '{1, 1, 0, 1, 1, 1, 0};
    vecs[14] = '{1, 1, 1, 1, 0, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 0, 0, 0};
    vecs[16] = '{1, 1, 1, 0, 0, 0, 0};
    vecs[17] = '{1, 1, 0, 1, 1, 1, 0};
    vecs[18] = '{1, 0, 0, 1, 0, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    en    = 1'b1;
    #2;

    for (int i = 0; i < 20; i++) begin
      rst_n = vecs[i].rst_n;
      en    = vecs[i].en;
      step();
      cmp($sformatf("vec%0d.count", i),     int'(cnt2), vecs[i].cnt);
      cmp($sformatf("vec%0d.outputCLK", i), int'(oc2),  int'(vecs[i].oc));
      cmp($sformatf("vec%0d.tick", i),      int'(tk2),  int'(vecs[i].tk));
      cmp($sformatf("vec%0d.rise", i),      int'(ri2),  int'(vecs[i].ri));
      cmp($sformatf("vec%0d.fall", i),      int'(fa2),  int'(vecs[i].fa));
    end

    // Randomized enable with occasional mid-phase resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      en    = ($urandom_range(0, 4) != 0);
      step();
    end

    // Free run from reset: period and duty of the divider=2 output.
    rst_n = 1'b0;
    en    = 1'b1;
    step();
    rst_n       = 1'b1;
    last_rise   = -1;
    last_strobe = -1;
    for (int cyc = 0; cyc < 80000; cyc++) begin
      step();
      if (ri2) begin
        if (last_rise >= 0) cmp("period_d2", cyc - last_rise, 4);
        if (last_strobe >= 0) cmp("alternate_rise", last_strobe, 0);
        last_rise   = cyc;
        last_strobe = 1;
      end
      if (fa2) begin
        cmp("high_time_d2", cyc - last_rise, 2);
        cmp("alternate_fall", last_strobe, 1);
        last_strobe = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
